// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS fetch stage
package mips_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } if_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  // Force an address onto a word boundary; the low two bits are never fetched.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/mips_if_stage_if.sv
// rtl/mips_if_stage_if.sv - instruction-memory request/response port
interface mips_if_stage_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  // Fetch stage side: issues requests, receives instruction words.
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  // Memory side: accepts requests, returns one response per accepted request.
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/mips_if_buf.sv
// rtl/mips_if_buf.sv - single-entry holding register for a fetched instruction
module mips_if_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        load,
  input  logic        consume,
  input  logic [31:0] load_data,
  input  logic [31:0] load_pc4,
  output logic        valid,
  output logic [31:0] data,
  output logic [31:0] pc4
);

  // Flush beats load beats consume; data and pc4 only change on a load so
  // a stalled consumer sees a stable instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= 32'h0000_0000;
      pc4   <= 32'h0000_0000;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc4   <= load_pc4;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mips_if_stage.sv
// rtl/mips_if_stage.sv - MIPS instruction-fetch stage with single outstanding request
module mips_if_stage #(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  mips_if_stage_if.master        imem,
  output logic                   IF_valid,
  output logic [31:0]            IF_instr,
  output logic [31:0]            IF_pc4
);

  import mips_pkg::*;

  if_state_t   state;
  if_state_t   next_state;
  logic [31:0] pc;
  logic [31:0] pc_next4;
  logic        kill;
  logic        buf_valid;
  logic [31:0] buf_data;
  logic [31:0] buf_pc4;
  logic        consume;
  logic        req_fire;
  logic        rsp_take;

  assign consume  = buf_valid && !Stall;
  assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
  assign pc_next4 = pc + PC_INCR;

  assign imem.imem_req_addr = pc;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  // Next state: a response (kept, killed or dropped by redirect) always
  // returns to FETCH, so redirect needs no term here.
  always_comb begin
    next_state = state;
    case (state)
      FETCH: if (req_fire) next_state = WAIT;
      WAIT:  if (imem.imem_rsp_valid) next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  // Outputs: request only when the buffer will be free; gated by reset so
  // the port is quiet while reset is held.
  always_comb begin
    imem.imem_req_valid = 1'b0;
    rsp_take            = 1'b0;
    case (state)
      FETCH: imem.imem_req_valid = reset && (!buf_valid || consume) && !redirect_valid;
      WAIT:  rsp_take = imem.imem_rsp_valid && !kill && !redirect_valid;
      default: ;
    endcase
  end

  // PC and kill flag: redirect always wins; a redirect while waiting with
  // no response marks the in-flight response as stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc   <= RESET_PC;
      kill <= 1'b0;
    end else if (redirect_valid) begin
      pc <= word_align(redirect_pc);
      if (state == WAIT) kill <= !imem.imem_rsp_valid;
    end else begin
      if (rsp_take) pc <= pc_next4;
      if (state == WAIT && imem.imem_rsp_valid) kill <= 1'b0;
    end
  end

  mips_if_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .load      (rsp_take),
    .consume   (consume),
    .load_data (imem.imem_rsp_data),
    .load_pc4  (pc_next4),
    .valid     (buf_valid),
    .data      (buf_data),
    .pc4       (buf_pc4)
  );

  assign IF_valid = buf_valid;
  assign IF_instr = buf_valid ? buf_data : NOP_INSTR;
  assign IF_pc4   = buf_pc4;

endmodule

// File: tb/tb_mips_if_stage.sv
// tb/tb_mips_if_stage.sv - directed self-checking bench for mips_if_stage
module tb_mips_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        IF_valid;
  logic [31:0] IF_instr;
  logic [31:0] IF_pc4;

  int          checks = 0;
  int          errors = 0;

  int          lat;
  int          pend_cnt;
  logic [31:0] pend_addr;
  logic        ovr_en;
  logic [31:0] ovr_data;

  always #5 clk = ~clk;

  mips_if_stage_if imem ();

  mips_if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .Stall          (Stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .IF_valid       (IF_valid),
    .IF_instr       (IF_instr),
    .IF_pc4         (IF_pc4)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h8C01_0004 : (32'h1000_0000 | a);
  endfunction

  // One clock: sample the request before the edge, then play the memory
  // model (fixed latency lat, optional data override) just after it.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = imem.imem_req_valid && imem.imem_req_ready;
    a   = imem.imem_req_addr;
    @(posedge clk);
    #1;
    imem.imem_rsp_valid = 1'b0;
    if (acc) begin
      pend_addr = a;
      pend_cnt  = lat;
    end
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = ovr_en ? ovr_data : mem_word(pend_addr);
      end
    end
  endtask

  initial begin
    reset               = 1'b0;
    Stall               = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = 32'h0;
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0;
    lat       = 1;
    pend_cnt  = 0;
    pend_addr = 32'h0;
    ovr_en    = 1'b0;
    ovr_data  = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    expect_eq("rst_req_valid", {31'b0, imem.imem_req_valid}, 32'h0);
    expect_eq("rst_if_valid",  {31'b0, IF_valid}, 32'h0);
    expect_eq("rst_if_instr",  IF_instr, 32'h0);
    expect_eq("rst_if_pc4",    IF_pc4, 32'h0);

    // First fetch from address 0.
    reset = 1'b1;
    #1;
    expect_eq("c1_req_valid", {31'b0, imem.imem_req_valid}, 32'h1);
    expect_eq("c1_req_addr",  imem.imem_req_addr, 32'h0);
    tick();
    expect_eq("c2_req_valid", {31'b0, imem.imem_req_valid}, 32'h0);
    expect_eq("c2_if_valid",  {31'b0, IF_valid}, 32'h0);
    tick();
    expect_eq("c3_if_valid",  {31'b0, IF_valid}, 32'h1);
    expect_eq("c3_if_instr",  IF_instr, 32'h8C01_0004);
    expect_eq("c3_if_pc4",    IF_pc4, 32'h4);
    expect_eq("c3_req_valid", {31'b0, imem.imem_req_valid}, 32'h1);
    expect_eq("c3_req_addr",  imem.imem_req_addr, 32'h4);

    // Stall holds the buffer and blocks new requests.
    Stall = 1'b1;
    #1;
    expect_eq("stall_req_valid", {31'b0, imem.imem_req_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_eq("stall_instr",     IF_instr, 32'h8C01_0004);
      expect_eq("stall_pc4",       IF_pc4, 32'h4);
      expect_eq("stall_addr",      imem.imem_req_addr, 32'h4);
      expect_eq("stall_req_valid", {31'b0, imem.imem_req_valid}, 32'h0);
    end
    Stall = 1'b0;
    #1;
    expect_eq("unstall_req_valid", {31'b0, imem.imem_req_valid}, 32'h1);
    expect_eq("unstall_req_addr",  imem.imem_req_addr, 32'h4);
    tick();
    expect_eq("f2_wait_if_valid", {31'b0, IF_valid}, 32'h0);
    tick();
    expect_eq("f2_if_instr", IF_instr, 32'h1000_0004);
    expect_eq("f2_if_pc4",   IF_pc4, 32'h8);
    expect_eq("f2_req_addr", imem.imem_req_addr, 32'h8);

    // Redirect together with Stall while the buffer is full.
    Stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    expect_eq("rs_req_valid", {31'b0, imem.imem_req_valid}, 32'h0);
    tick();
    Stall          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    expect_eq("rs_if_valid",  {31'b0, IF_valid}, 32'h0);
    expect_eq("rs_if_instr",  IF_instr, 32'h0);
    expect_eq("rs_req_valid", {31'b0, imem.imem_req_valid}, 32'h1);
    expect_eq("rs_req_addr",  imem.imem_req_addr, 32'h200);
    tick();
    tick();
    expect_eq("rs_fetch_instr", IF_instr, 32'h1000_0200);
    expect_eq("rs_fetch_pc4",   IF_pc4, 32'h204);

    // Redirect during WAIT: the late response must be discarded.
    lat = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    ovr_en         = 1'b1;
    ovr_data       = 32'hDEAD_BEEF;
    #1;
    expect_eq("rw_req_valid", {31'b0, imem.imem_req_valid}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    expect_eq("rw_if_valid_a", {31'b0, IF_valid}, 32'h0);
    expect_eq("rw_req_valid_a", {31'b0, imem.imem_req_valid}, 32'h0);
    tick();
    expect_eq("rw_stale_rsp",  {31'b0, imem.imem_rsp_valid}, 32'h1);
    expect_eq("rw_if_valid_b", {31'b0, IF_valid}, 32'h0);
    tick();
    expect_eq("rw_if_valid_c", {31'b0, IF_valid}, 32'h0);
    expect_eq("rw_if_instr",   IF_instr, 32'h0);
    expect_eq("rw_req_valid",  {31'b0, imem.imem_req_valid}, 32'h1);
    expect_eq("rw_req_addr",   imem.imem_req_addr, 32'h100);
    lat    = 1;
    ovr_en = 1'b0;
    tick();
    tick();
    expect_eq("rw_fetch_valid", {31'b0, IF_valid}, 32'h1);
    expect_eq("rw_fetch_instr", IF_instr, 32'h1000_0100);
    expect_eq("rw_fetch_pc4",   IF_pc4, 32'h104);

    // PC wraps from the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    expect_eq("wrap_req_addr", imem.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    expect_eq("wrap_if_instr",  IF_instr, 32'hFFFF_FFFC);
    expect_eq("wrap_if_pc4",    IF_pc4, 32'h0);
    expect_eq("wrap_req_valid", {31'b0, imem.imem_req_valid}, 32'h1);
    expect_eq("wrap_req_addr2", imem.imem_req_addr, 32'h0);

    // Refill from 0, then hold ready low with a request pending.
    tick();
    tick();
    expect_eq("bp_if_pc4", IF_pc4, 32'h4);
    imem.imem_req_ready = 1'b0;
    lat = 3;
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_eq("bp_req_valid", {31'b0, imem.imem_req_valid}, 32'h1);
      expect_eq("bp_req_addr",  imem.imem_req_addr, 32'h4);
    end
    imem.imem_req_ready = 1'b1;
    tick();
    expect_eq("bp_wait_req_valid", {31'b0, imem.imem_req_valid}, 32'h0);

    // Asynchronous reset in the middle of WAIT.
    #3;
    reset = 1'b0;
    #1;
    expect_eq("arst_req_valid", {31'b0, imem.imem_req_valid}, 32'h0);
    expect_eq("arst_if_valid",  {31'b0, IF_valid}, 32'h0);
    expect_eq("arst_if_instr",  IF_instr, 32'h0);
    expect_eq("arst_if_pc4",    IF_pc4, 32'h0);
    expect_eq("arst_req_addr",  imem.imem_req_addr, 32'h0);
    pend_cnt            = 0;
    imem.imem_rsp_valid = 1'b0;
    lat                 = 1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    expect_eq("rel_req_valid", {31'b0, imem.imem_req_valid}, 32'h1);
    expect_eq("rel_req_addr",  imem.imem_req_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
